vcpu_alu_issue: RTL and testbench

//  Issue/writeback sequencer on the initiator side of the vcpu_alu interface.

---
 rtl/vcpu_pkg.sv | 19 +
 rtl/vcpu_alu_issue_if.sv | 53 +++++
 rtl/vcpu_regfile.sv | 46 ++++
 rtl/vcpu_alu_issue.sv | 148 ++++++++++++++
 tb/tb_vcpu_alu_issue.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vcpu_pkg.sv
// Shared definitions for the vcpu ALU issue/writeback path.
package vcpu_pkg;

  localparam int DATA_W = 8;
  localparam int NREGS  = 8;
  localparam int REG_AW = $clog2(NREGS);

  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  // Sequencer states: accept in IDLE, one ALU cycle in EXEC,
  // result retirement in WB, illegal-opcode report in ERR.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    ERR  = 2'd3
  } state_t;

endpackage : vcpu_pkg

// File: rtl/vcpu_alu_issue_if.sv
// Request, ALU and status signals of the issue/writeback sequencer.
// slave: the sequencer itself. master: decode stage plus the external ALU.
interface vcpu_alu_issue_if;
  import vcpu_pkg::*;

  // request from decode
  logic              req_valid;
  logic              req_ready;
  logic              req_ldi;
  logic [DATA_W-1:0] req_imm;
  logic [2:0]        req_op;
  logic              req_cmp;
  logic [REG_AW-1:0] req_rd;
  logic [REG_AW-1:0] req_rs;
  logic [REG_AW-1:0] req_rt;

  // combinational ALU
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_c;
  logic              alu_eq;

  // status
  logic              done;
  logic              flag_eq;
  logic              err_illegal;

  // debug register read
  logic [REG_AW-1:0] dbg_rsel;
  logic [DATA_W-1:0] dbg_rdata;

  modport slave (
    input  req_valid, req_ldi, req_imm, req_op, req_cmp, req_rd, req_rs, req_rt,
    output req_ready,
    output alu_op, alu_a, alu_b,
    input  alu_c, alu_eq,
    output done, flag_eq, err_illegal,
    input  dbg_rsel,
    output dbg_rdata
  );

  modport master (
    output req_valid, req_ldi, req_imm, req_op, req_cmp, req_rd, req_rs, req_rt,
    input  req_ready,
    input  alu_op, alu_a, alu_b,
    output alu_c, alu_eq,
    input  done, flag_eq, err_illegal,
    output dbg_rsel,
    input  dbg_rdata
  );

endinterface : vcpu_alu_issue_if

// File: rtl/vcpu_regfile.sv
// Register file: NREGS x DATA_W, two async read ports plus a debug port,
// one synchronous write port. r0 is hard-wired to zero.
module vcpu_regfile
  import vcpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [NREGS-1:0][DATA_W-1:0] regs_q;
  logic [NREGS-1:0][DATA_W-1:0] regs_d;

  // Next-state of every register; r0 never takes a write.
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NREGS; i++) begin
      if (we && (waddr == REG_AW'(i))) begin
        regs_d[i] = wdata;
      end
    end
    regs_d[0] = '0;
  end

  // Storage; cleared asynchronously so a mid-operation reset wipes state at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a  = regs_q[raddr_a];
  assign rdata_b  = regs_q[raddr_b];
  assign dbg_data = regs_q[dbg_addr];

endmodule : vcpu_regfile

// File: rtl/vcpu_alu_issue.sv
// Issue/writeback sequencer in front of the combinational vcpu_alu.
// Accepts one request at a time, registers op/a/b for the ALU, captures the
// result after one full ALU cycle and writes it back to the register file.
module vcpu_alu_issue
  import vcpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  vcpu_alu_issue_if.slave bus
);

  state_t            state_q,   state_d;
  logic [REG_AW-1:0] rd_q,      rd_d;
  logic              cmp_q,     cmp_d;
  logic              ldi_q,     ldi_d;
  logic [DATA_W-1:0] res_q,     res_d;
  logic              eq_q,      eq_d;
  logic [2:0]        alu_op_q,  alu_op_d;
  logic [DATA_W-1:0] alu_a_q,   alu_a_d;
  logic [DATA_W-1:0] alu_b_q,   alu_b_d;
  logic              done_q,    done_d;
  logic              err_q,     err_d;
  logic              flag_eq_q, flag_eq_d;

  logic              wb_we;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] dbg_data;

  vcpu_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .raddr_a  (bus.req_rs),
    .rdata_a  (rs_data),
    .raddr_b  (bus.req_rt),
    .rdata_b  (rt_data),
    .dbg_addr (bus.dbg_rsel),
    .dbg_data (dbg_data),
    .we       (wb_we),
    .waddr    (rd_q),
    .wdata    (res_q)
  );

  // FSM next-state and datapath capture. done/err pulses are computed one
  // edge ahead so they come straight out of flops while in WB/ERR.
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    cmp_d     = cmp_q;
    ldi_d     = ldi_q;
    res_d     = res_q;
    eq_d      = eq_q;
    alu_op_d  = alu_op_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    flag_eq_d = flag_eq_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    wb_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          rd_d = bus.req_rd;
          if (bus.req_ldi) begin
            // immediate goes straight to writeback; ALU outputs untouched
            ldi_d   = 1'b1;
            cmp_d   = 1'b0;
            res_d   = bus.req_imm;
            state_d = WB;
            done_d  = 1'b1;
          end else if (bus.req_op == OP_ILLEGAL) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            // operands are sampled here, so rs/rt == rd needs no forwarding
            ldi_d    = 1'b0;
            cmp_d    = bus.req_cmp;
            alu_op_d = bus.req_op;
            alu_a_d  = rs_data;
            alu_b_d  = rt_data;
            state_d  = EXEC;
          end
        end
      end
      EXEC: begin
        res_d   = bus.alu_c;
        eq_d    = bus.alu_eq;
        state_d = WB;
        done_d  = 1'b1;
      end
      WB: begin
        wb_we   = !cmp_q;
        if (!ldi_q) begin
          flag_eq_d = eq_q;
        end
        state_d = IDLE;
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All sequencer state; asynchronous reset returns to IDLE with no pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      cmp_q     <= 1'b0;
      ldi_q     <= 1'b0;
      res_q     <= '0;
      eq_q      <= 1'b0;
      alu_op_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      flag_eq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      cmp_q     <= cmp_d;
      ldi_q     <= ldi_d;
      res_q     <= res_d;
      eq_q      <= eq_d;
      alu_op_q  <= alu_op_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      done_q    <= done_d;
      err_q     <= err_d;
      flag_eq_q <= flag_eq_d;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.done        = done_q;
  assign bus.err_illegal = err_q;
  assign bus.flag_eq     = flag_eq_q;
  assign bus.dbg_rdata   = dbg_data;

endmodule : vcpu_alu_issue

// File: tb/tb_vcpu_alu_issue.sv
// Bench for vcpu_alu_issue: directed instructions, a transaction-level model
// of registers/flag/expected outputs, and a per-cycle compare process.
module tb_vcpu_alu_issue;
  import vcpu_pkg::*;

  logic clk;
  logic reset;

  vcpu_alu_issue_if bus ();

  vcpu_alu_issue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural ALU standing in for vcpu_alu
  function automatic logic [DATA_W-1:0] alu_fn(input logic [2:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return '0;
    endcase
  endfunction

  assign bus.alu_c  = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
  assign bus.alu_eq = (bus.alu_a == bus.alu_b);

  // model state
  logic [DATA_W-1:0] model_regs [NREGS];
  logic              exp_ready;
  logic              exp_done;
  logic              exp_err;
  logic              exp_flag;
  logic [2:0]        exp_op;
  logic [DATA_W-1:0] exp_a;
  logic [DATA_W-1:0] exp_b;
  logic              check_en;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      check("req_ready",   bus.req_ready,   exp_ready);
      check("done",        bus.done,        exp_done);
      check("err_illegal", bus.err_illegal, exp_err);
      check("flag_eq",     bus.flag_eq,     exp_flag);
      check("alu_op",      bus.alu_op,      exp_op);
      check("alu_a",       bus.alu_a,       exp_a);
      check("alu_b",       bus.alu_b,       exp_b);
      check("dbg_rdata",   bus.dbg_rdata,   model_regs[bus.dbg_rsel]);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) model_regs[i] = '0;
    exp_ready = 1'b1;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    exp_flag  = 1'b0;
    exp_op    = '0;
    exp_a     = '0;
    exp_b     = '0;
  endtask

  task automatic drive_req(input logic ldi, input logic [DATA_W-1:0] imm,
                           input logic [2:0] op, input logic cmp,
                           input int rd, input int rs, input int rt);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_ldi   = ldi;
    bus.req_imm   = imm;
    bus.req_op    = op;
    bus.req_cmp   = cmp;
    bus.req_rd    = REG_AW'(rd);
    bus.req_rs    = REG_AW'(rs);
    bus.req_rt    = REG_AW'(rt);
    bus.dbg_rsel  = REG_AW'(rd);
    @(posedge clk); #1;   // accepted at that edge
    bus.req_valid = 1'b0;
  endtask

  // one instruction, model updated on the cycle boundaries the protocol defines
  task automatic issue(input logic ldi, input logic [DATA_W-1:0] imm,
                       input logic [2:0] op, input logic cmp,
                       input int rd, input int rs, input int rt);
    logic [DATA_W-1:0] a, b, c;
    logic eq;
    a = model_regs[rs];
    b = model_regs[rt];
    drive_req(ldi, imm, op, cmp, rd, rs, rt);
    exp_ready = 1'b0;
    if (ldi) begin
      exp_done = 1'b1;
      @(posedge clk); #1;
      if (rd != 0) model_regs[rd] = imm;
      exp_done  = 1'b0;
      exp_ready = 1'b1;
      $display("txn LDI r%0d <= %0d", rd, imm);
    end else if (op == OP_ILLEGAL) begin
      exp_err = 1'b1;
      @(posedge clk); #1;
      exp_err   = 1'b0;
      exp_ready = 1'b1;
      $display("txn ILLEGAL op=%0d", op);
    end else begin
      c = alu_fn(op, a, b);
      eq = (a == b);
      exp_op = op;
      exp_a  = a;
      exp_b  = b;
      @(posedge clk); #1;   // now in WB
      exp_done = 1'b1;
      @(posedge clk); #1;
      exp_done  = 1'b0;
      exp_ready = 1'b1;
      if (!cmp && rd != 0) model_regs[rd] = c;
      exp_flag = eq;
      $display("txn ALU op=%0d cmp=%0d r%0d=%0d r%0d=%0d -> r%0d c=%0d eq=%0d",
               op, cmp, rs, a, rt, b, rd, c, eq);
    end
  endtask

  task automatic sweep_regs();
    for (int i = 0; i < NREGS; i++) begin
      bus.dbg_rsel = REG_AW'(i);
      @(negedge clk);
    end
    #1;
  endtask

  // literal expectation on a register, independent of the model
  task automatic pin_reg(input string name, input int r, input int unsigned val);
    bus.dbg_rsel = REG_AW'(r);
    #1;
    check(name, bus.dbg_rdata, val);
  endtask

  initial begin
    check_en      = 1'b0;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_ldi   = 1'b0;
    bus.req_imm   = '0;
    bus.req_op    = '0;
    bus.req_cmp   = 1'b0;
    bus.req_rd    = '0;
    bus.req_rs    = '0;
    bus.req_rt    = '0;
    bus.dbg_rsel  = '0;
    model_reset();
    #1 check_en = 1'b1;

    // 1: reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    sweep_regs();

    // 2: immediates
    issue(1'b1, 8'd23, 3'd0, 1'b0, 1, 0, 0);
    issue(1'b1, 8'd44, 3'd0, 1'b0, 2, 0, 0);
    pin_reg("lit_r1", 1, 23);
    pin_reg("lit_r2", 2, 44);

    // 3: add
    issue(1'b0, 8'd0, 3'd0, 1'b0, 3, 1, 2);
    pin_reg("lit_r3", 3, 67);
    check("lit_flag_after_add", bus.flag_eq, 0);

    // 4: compare-only, equal operands
    issue(1'b0, 8'd0, 3'd1, 1'b1, 3, 1, 1);
    check("lit_flag_after_cmp", bus.flag_eq, 1);
    pin_reg("lit_r3_kept", 3, 67);

    // 5: illegal opcode
    issue(1'b0, 8'd0, 3'd7, 1'b0, 4, 1, 2);
    check("lit_flag_after_err", bus.flag_eq, 1);
    pin_reg("lit_r4_untouched", 4, 0);

    // further patterns: sub, xor, rd hazard
    issue(1'b0, 8'd0, 3'd1, 1'b0, 4, 2, 1);
    pin_reg("lit_r4_sub", 4, 21);
    issue(1'b0, 8'd0, 3'd4, 1'b0, 5, 3, 1);
    pin_reg("lit_r5_xor", 5, 84);
    issue(1'b0, 8'd0, 3'd0, 1'b0, 1, 1, 1);
    pin_reg("lit_r1_hazard", 1, 46);

    // 6a: LDI to r0 dropped
    issue(1'b1, 8'd5, 3'd0, 1'b0, 0, 0, 0);
    pin_reg("lit_r0", 0, 0);
    sweep_regs();

    // 6b: reset during EXEC
    drive_req(1'b0, 8'd0, 3'd0, 1'b0, 2, 3, 4);
    exp_ready = 1'b0;
    exp_op    = 3'd0;
    exp_a     = model_regs[3];
    exp_b     = model_regs[4];
    #1;
    reset = 1'b1;
    model_reset();
    $display("txn RESET during EXEC");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sweep_regs();
    pin_reg("lit_r1_cleared", 1, 0);
    check("lit_flag_cleared", bus.flag_eq, 0);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_vcpu_alu_issue
